// File: rtl/imm_gen_pipe.sv
// Registered RV32I/RV64I immediate generator with a valid/ready stage and a 2-entry skid buffer.
// Optional feature macro IMM_GEN_TARGET_EN adds out_target = tag + imm computed at capture.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [2:0]       in_sel,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [TAG_W-1:0] out_tag,
  output logic [XLEN-1:0]  out_target,
  output logic             out_illegal
);

  // Handshake: a beat moves in on in_valid & in_ready and out on out_valid & out_ready.
  // in_ready depends only on skid occupancy, so there is no path from out_ready to in_ready.

  logic [63:0]      imm_wide;
  logic [XLEN-1:0]  new_imm;
  logic             new_illegal;

  // Decode at 64 bits, then keep the low XLEN bits.
  always_comb begin
    imm_wide = '0;
    case (in_sel)
      3'b000:  imm_wide = {{32{in_inst[31]}}, in_inst[31:12], 12'b0};
      3'b001:  imm_wide = {{52{in_inst[31]}}, in_inst[31:20]};
      3'b010:  imm_wide = {{52{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
      3'b011:  imm_wide = {{51{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25],
                           in_inst[11:8], 1'b0};
      3'b100:  imm_wide = {{43{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20],
                           in_inst[30:21], 1'b0};
      3'b101:  imm_wide = (XLEN == 64) ? {58'b0, in_inst[25:20]} : {59'b0, in_inst[24:20]};
      3'b110:  imm_wide = {59'b0, in_inst[19:15]};
      default: imm_wide = '0;
    endcase
  end

  assign new_imm     = imm_wide[XLEN-1:0];
  assign new_illegal = (in_sel == 3'b111);

  logic             main_valid, skid_valid;
  logic [XLEN-1:0]  main_imm, skid_imm;
  logic [TAG_W-1:0] main_tag, skid_tag;
  logic             main_illegal, skid_illegal;

  logic accept, main_load, main_from_skid, skid_load;

  assign in_ready       = ~skid_valid;
  assign accept         = in_valid & in_ready & ~flush;
  // Main can take an entry when it is empty or its current entry leaves this edge.
  assign main_load      = ~main_valid | out_ready;
  assign main_from_skid = main_load & skid_valid;
  assign skid_load      = accept & ~main_load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else begin
      if (main_load) main_valid <= skid_valid | accept;
      skid_valid <= skid_load | (skid_valid & ~main_load);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_imm     <= '0;
      main_tag     <= '0;
      main_illegal <= 1'b0;
      skid_imm     <= '0;
      skid_tag     <= '0;
      skid_illegal <= 1'b0;
    end else begin
      if (main_from_skid) begin
        main_imm     <= skid_imm;
        main_tag     <= skid_tag;
        main_illegal <= skid_illegal;
      end else if (main_load && accept) begin
        main_imm     <= new_imm;
        main_tag     <= in_tag;
        main_illegal <= new_illegal;
      end
      if (skid_load) begin
        skid_imm     <= new_imm;
        skid_tag     <= in_tag;
        skid_illegal <= new_illegal;
      end
    end
  end

  assign out_valid   = main_valid;
  assign out_imm     = main_imm;
  assign out_tag     = main_tag;
  assign out_illegal = main_illegal;

`ifdef IMM_GEN_TARGET_EN
  logic [XLEN+TAG_W-1:0] tag_wide;
  logic [XLEN-1:0]       new_target, main_target, skid_target;

  // Tag is zero-extended or truncated to XLEN; the sum wraps.
  assign tag_wide   = {{XLEN{1'b0}}, in_tag};
  assign new_target = tag_wide[XLEN-1:0] + new_imm;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_target <= '0;
      skid_target <= '0;
    end else begin
      if (main_from_skid)          main_target <= skid_target;
      else if (main_load && accept) main_target <= new_target;
      if (skid_load)               skid_target <= new_target;
    end
  end

  assign out_target = main_target;

  logic unused_bits;
  assign unused_bits = ^{imm_wide, in_inst[6:0], tag_wide};
`else
  assign out_target = '0;

  logic unused_bits;
  assign unused_bits = ^{imm_wide, in_inst[6:0]};
`endif

endmodule
